div_sequencer: RTL and testbench

//  Multi-cycle control and sign-handling stage around the combinational unsigned divider
//  in the mini CPU execute path.
//  - Upstream: latches the operands and drives unsigned magnitudes into the divider.
//  - Holds them stable for a fixed settle time (multicycle path), then captures the

---
 rtl/div_sequencer_pkg.sv | 15 +
 rtl/div_sequencer_if.sv | 38 +++
 rtl/div_sequencer_cond_negate.sv | 31 +++
 rtl/div_sequencer.sv | 182 ++++++++++++++++++
 tb/tb_div_sequencer.sv | 408 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/div_sequencer_pkg.sv
// Shared execute-stage types and constants for the divide sequencer.
package div_sequencer_pkg;

    localparam int WORD_W = 32;

    localparam logic [WORD_W-1:0] DIV_ZERO_QUOT = '1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        WRITE  = 2'd2,
        ZERO   = 2'd3
    } div_state_t;

endpackage

// File: rtl/div_sequencer_if.sv
// Pipeline-facing and divider-facing signals of the divide sequencer.
// The master is the pipeline plus divider; the slave is the sequencer.
interface div_sequencer_if
    import div_sequencer_pkg::*;
#(
    parameter int WIDTH = WORD_W
) ();

    logic             start;
    logic             is_signed;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             mthi;
    logic             mtlo;
    logic [WIDTH-1:0] wdata;

    logic [WIDTH-1:0] div_a;
    logic [WIDTH-1:0] div_b;
    logic [WIDTH-1:0] div_q;
    logic [WIDTH-1:0] div_r;

    logic             busy;
    logic             done;
    logic             div_by_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, is_signed, op_a, op_b, mthi, mtlo, wdata, div_q, div_r,
        input  div_a, div_b, busy, done, div_by_zero, hi, lo
    );

    modport slave (
        input  start, is_signed, op_a, op_b, mthi, mtlo, wdata, div_q, div_r,
        output div_a, div_b, busy, done, div_by_zero, hi, lo
    );

endinterface

// File: rtl/div_sequencer_cond_negate.sv
// Two's complement negate and a conditional wrapper; purely combinational, no handshake.
// Negation wraps modulo 2^WIDTH, so the most negative value maps to itself.
module negate_val #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_val,
    output logic [WIDTH-1:0] o_val
);

    assign o_val = (~i_val) + WIDTH'(1);

endmodule

module cond_negate #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_val,
    input  logic             i_neg,
    output logic [WIDTH-1:0] o_val
);

    logic [WIDTH-1:0] w_negated;

    negate_val #(.WIDTH(WIDTH)) u_negate (
        .i_val (i_val),
        .o_val (w_negated)
    );

    assign o_val = i_neg ? w_negated : i_val;

endmodule

// File: rtl/div_sequencer.sv
// Sign handling and multicycle sequencing around a combinational unsigned divider.
// HI/LO land SETTLE_CYCLES+1 edges after start; busy stalls the pipeline, start while busy is dropped.
module div_sequencer
    import div_sequencer_pkg::*;
#(
    parameter int WIDTH         = WORD_W,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    div_sequencer_if.slave   bus
);

    localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);

    div_state_t       r_state;
    div_state_t       w_state_nxt;

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_busy;
    logic             w_busy_nxt;
    logic             r_done;
    logic             w_done_nxt;
    logic             r_dbz;
    logic             w_dbz_nxt;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] w_hi_nxt;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] w_lo_nxt;
    logic [WIDTH-1:0] r_div_a;
    logic [WIDTH-1:0] w_div_a_nxt;
    logic [WIDTH-1:0] r_div_b;
    logic [WIDTH-1:0] w_div_b_nxt;
    logic             r_neg_q;
    logic             w_neg_q_nxt;
    logic             r_neg_r;
    logic             w_neg_r_nxt;
    logic [WIDTH-1:0] r_zero_hi;
    logic [WIDTH-1:0] w_zero_hi_nxt;

    logic             w_neg_a;
    logic             w_neg_b;
    logic [WIDTH-1:0] w_mag_a;
    logic [WIDTH-1:0] w_mag_b;
    logic [WIDTH-1:0] w_quot;
    logic [WIDTH-1:0] w_rem;

    assign w_neg_a = bus.is_signed & bus.op_a[WIDTH-1];
    assign w_neg_b = bus.is_signed & bus.op_b[WIDTH-1];

    cond_negate #(.WIDTH(WIDTH)) u_mag_a (
        .i_val (bus.op_a),
        .i_neg (w_neg_a),
        .o_val (w_mag_a)
    );

    cond_negate #(.WIDTH(WIDTH)) u_mag_b (
        .i_val (bus.op_b),
        .i_neg (w_neg_b),
        .o_val (w_mag_b)
    );

    // The divider output is only sampled in WRITE, after div_a/div_b have been stable long enough.
    cond_negate #(.WIDTH(WIDTH)) u_fix_q (
        .i_val (bus.div_q),
        .i_neg (r_neg_q),
        .o_val (w_quot)
    );

    cond_negate #(.WIDTH(WIDTH)) u_fix_r (
        .i_val (bus.div_r),
        .i_neg (r_neg_r),
        .o_val (w_rem)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_dbz     <= 1'b0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_div_a   <= '0;
            r_div_b   <= '0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_zero_hi <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
            r_dbz     <= w_dbz_nxt;
            r_hi      <= w_hi_nxt;
            r_lo      <= w_lo_nxt;
            r_div_a   <= w_div_a_nxt;
            r_div_b   <= w_div_b_nxt;
            r_neg_q   <= w_neg_q_nxt;
            r_neg_r   <= w_neg_r_nxt;
            r_zero_hi <= w_zero_hi_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_busy_nxt    = r_busy;
        w_done_nxt    = 1'b0;
        w_dbz_nxt     = r_dbz;
        w_hi_nxt      = r_hi;
        w_lo_nxt      = r_lo;
        w_div_a_nxt   = r_div_a;
        w_div_b_nxt   = r_div_b;
        w_neg_q_nxt   = r_neg_q;
        w_neg_r_nxt   = r_neg_r;
        w_zero_hi_nxt = r_zero_hi;

        unique case (r_state)
            IDLE: begin
                // Moves land this edge; a divide accepted alongside overwrites HI/LO later.
                if (bus.mthi) begin
                    w_hi_nxt = bus.wdata;
                end
                if (bus.mtlo) begin
                    w_lo_nxt = bus.wdata;
                end
                if (bus.start) begin
                    w_busy_nxt = 1'b1;
                    w_dbz_nxt  = 1'b0;
                    if (bus.op_b == '0) begin
                        w_zero_hi_nxt = bus.op_a;
                        w_state_nxt   = ZERO;
                    end else begin
                        w_div_a_nxt = w_mag_a;
                        w_div_b_nxt = w_mag_b;
                        w_neg_q_nxt = bus.is_signed & (bus.op_a[WIDTH-1] ^ bus.op_b[WIDTH-1]);
                        w_neg_r_nxt = w_neg_a;
                        w_cnt_nxt   = CNT_W'(SETTLE_CYCLES - 1);
                        w_state_nxt = SETTLE;
                    end
                end
            end
            SETTLE: begin
                if (r_cnt == '0) begin
                    w_state_nxt = WRITE;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            WRITE: begin
                w_lo_nxt    = w_quot;
                w_hi_nxt    = w_rem;
                w_busy_nxt  = 1'b0;
                w_done_nxt  = 1'b1;
                w_state_nxt = IDLE;
            end
            ZERO: begin
                w_hi_nxt    = r_zero_hi;
                w_lo_nxt    = {WIDTH{1'b1}};
                w_dbz_nxt   = 1'b1;
                w_busy_nxt  = 1'b0;
                w_done_nxt  = 1'b1;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign bus.div_a       = r_div_a;
    assign bus.div_b       = r_div_b;
    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.div_by_zero = r_dbz;
    assign bus.hi          = r_hi;
    assign bus.lo          = r_lo;

endmodule

// File: tb/tb_div_sequencer.sv
// Bench for div_sequencer: three instances (settle 4, 1, 8) each paired with a behavioural divider;
// results are scoreboarded on the done pulse against expectations queued at start.
module tb_div_sequencer;

    localparam int NDUT = 3;

    typedef struct {
        int          dut;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
        int          due;
        string       name;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        is_signed;
    logic        mthi;
    logic        mtlo;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [31:0] wdata;
    logic        start_v [NDUT];

    logic        busy_v [NDUT];
    logic        done_v [NDUT];
    logic        dbz_v  [NDUT];
    logic [31:0] hi_v   [NDUT];
    logic [31:0] lo_v   [NDUT];
    logic [31:0] da_v   [NDUT];
    logic [31:0] db_v   [NDUT];

    int   total;
    int   bad;
    int   cyc = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        div_sequencer_if #(.WIDTH(32)) bus ();

        assign bus.start     = start_v[g];
        assign bus.is_signed = is_signed;
        assign bus.op_a      = op_a;
        assign bus.op_b      = op_b;
        assign bus.mthi      = mthi;
        assign bus.mtlo      = mtlo;
        assign bus.wdata     = wdata;
        assign bus.div_q     = (bus.div_b == 32'd0) ? 32'hFFFF_FFFF : bus.div_a / bus.div_b;
        assign bus.div_r     = (bus.div_b == 32'd0) ? bus.div_a : bus.div_a % bus.div_b;

        assign busy_v[g] = bus.busy;
        assign done_v[g] = bus.done;
        assign dbz_v[g]  = bus.div_by_zero;
        assign hi_v[g]   = bus.hi;
        assign lo_v[g]   = bus.lo;
        assign da_v[g]   = bus.div_a;
        assign db_v[g]   = bus.div_b;

        div_sequencer #(
            .WIDTH         (32),
            .SETTLE_CYCLES (g == 0 ? 4 : (g == 1 ? 1 : 8))
        ) u_dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (bus)
        );
    end

    function automatic int sc_of(input int i);
        return (i == 0) ? 4 : ((i == 1) ? 1 : 8);
    endfunction

    // Reference: 64-bit signed arithmetic truncates toward zero, remainder takes the dividend sign.
    function automatic logic [63:0] ref_div(input logic s, input logic [31:0] a, input logic [31:0] b);
        longint la;
        longint lb;
        longint q;
        longint r;
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (s) begin
            la = longint'($signed(a));
            lb = longint'($signed(b));
        end else begin
            la = longint'({32'd0, a});
            lb = longint'({32'd0, b});
        end
        q = la / lb;
        r = la % lb;
        return {r[31:0], q[31:0]};
    endfunction

    // Caller is just past a negedge; returns 1 time unit after the accepting edge.
    task automatic issue(input int mask, input logic s, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] ehi, input logic [31:0] elo, input logic edbz, input string nm);
        exp_t e;
        is_signed = s;
        op_a      = a;
        op_b      = b;
        for (int i = 0; i < NDUT; i++) if (mask[i]) start_v[i] = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < NDUT; i++) begin
            if (mask[i]) begin
                e.dut  = i;
                e.hi   = ehi;
                e.lo   = elo;
                e.dbz  = edbz;
                e.due  = (b == 32'd0) ? -1 : cyc + sc_of(i) + 1;
                e.name = nm;
                exp_q.push_back(e);
            end
        end
        for (int i = 0; i < NDUT; i++) start_v[i] = 1'b0;
        mthi = 1'b0;
        mtlo = 1'b0;
    endtask

    task automatic drain(input string nm);
        int c = 0;
        while (exp_q.size() != 0 && c < 60) begin
            @(negedge clk);
            c++;
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL %s_timeout pending=%0d want=0", nm, exp_q.size());
            exp_q.delete();
        end
        @(negedge clk);
    endtask

    task automatic monitor();
        logic        pbusy [NDUT];
        logic        pdone [NDUT];
        logic [31:0] pda   [NDUT];
        logic [31:0] pdb   [NDUT];
        int          k;
        exp_t        e;
        for (int i = 0; i < NDUT; i++) begin
            pbusy[i] = 1'b0;
            pdone[i] = 1'b0;
            pda[i]   = '0;
            pdb[i]   = '0;
        end
        forever begin
            @(negedge clk);
            for (int i = 0; i < NDUT; i++) begin
                if (rst_n && pbusy[i] && busy_v[i]) begin
                    total++;
                    if (da_v[i] !== pda[i] || db_v[i] !== pdb[i]) begin
                        bad++;
                        $display("FAIL hold_stable dut%0d div_a=%h div_b=%h want=%h/%h", i, da_v[i], db_v[i], pda[i], pdb[i]);
                    end
                end
                if (done_v[i] === 1'b1) begin
                    total++;
                    if (pdone[i]) begin
                        bad++;
                        $display("FAIL done_width dut%0d done high for 2+ cycles want=1 cycle", i);
                    end
                    k = -1;
                    for (int j = 0; j < exp_q.size(); j++) if (k < 0 && exp_q[j].dut == i) k = j;
                    total++;
                    if (k < 0) begin
                        bad++;
                        $display("FAIL spurious_done dut%0d got done=1 want no result pending", i);
                    end else begin
                        e = exp_q[k];
                        exp_q.delete(k);
                        if (hi_v[i] !== e.hi) begin
                            bad++;
                            $display("FAIL %s_hi dut%0d got=%h want=%h", e.name, i, hi_v[i], e.hi);
                        end
                        total++;
                        if (lo_v[i] !== e.lo) begin
                            bad++;
                            $display("FAIL %s_lo dut%0d got=%h want=%h", e.name, i, lo_v[i], e.lo);
                        end
                        total++;
                        if (dbz_v[i] !== e.dbz) begin
                            bad++;
                            $display("FAIL %s_dbz dut%0d got=%b want=%b", e.name, i, dbz_v[i], e.dbz);
                        end
                        total++;
                        if (busy_v[i] !== 1'b0) begin
                            bad++;
                            $display("FAIL %s_busy_at_done dut%0d got=%b want=0", e.name, i, busy_v[i]);
                        end
                        if (e.due >= 0) begin
                            total++;
                            if (cyc != e.due) begin
                                bad++;
                                $display("FAIL %s_latency dut%0d got=%0d want=%0d", e.name, i, cyc, e.due);
                            end
                        end
                    end
                end
                pbusy[i] = busy_v[i];
                pdone[i] = done_v[i];
                pda[i]   = da_v[i];
                pdb[i]   = db_v[i];
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < NDUT; i++) begin
            total++;
            if (hi_v[i] !== 32'd0 || lo_v[i] !== 32'd0) begin
                bad++;
                $display("FAIL reset_hilo dut%0d got=%h/%h want=0/0", i, hi_v[i], lo_v[i]);
            end
            total++;
            if (busy_v[i] !== 1'b0 || done_v[i] !== 1'b0 || dbz_v[i] !== 1'b0) begin
                bad++;
                $display("FAIL reset_flags dut%0d busy=%b done=%b dbz=%b want=0", i, busy_v[i], done_v[i], dbz_v[i]);
            end
            total++;
            if (da_v[i] !== 32'd0 || db_v[i] !== 32'd0) begin
                bad++;
                $display("FAIL reset_div_ab dut%0d got=%h/%h want=0/0", i, da_v[i], db_v[i]);
            end
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_unsigned();
        total++;
        if (busy_v[0] !== 1'b0) begin
            bad++;
            $display("FAIL busy_idle got=%b want=0", busy_v[0]);
        end
        issue(1, 1'b0, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, "udiv");
        total++;
        if (busy_v[0] !== 1'b1) begin
            bad++;
            $display("FAIL busy_accept got=%b want=1", busy_v[0]);
        end
        drain("udiv");
        total++;
        if (busy_v[0] !== 1'b0) begin
            bad++;
            $display("FAIL busy_release got=%b want=0", busy_v[0]);
        end
    endtask

    task automatic test_signed();
        issue(1, 1'b1, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFF2, 1'b0, "sdiv_neg_a");
        drain("sdiv_neg_a");
        issue(1, 1'b1, 32'd100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFF2, 1'b0, "sdiv_neg_b");
        drain("sdiv_neg_b");
    endtask

    task automatic test_ovf_zero();
        issue(1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0, "ovf");
        drain("ovf");
        issue(1, 1'b0, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1'b1, "dbz");
        drain("dbz");
        repeat (3) @(negedge clk);
        total++;
        if (dbz_v[0] !== 1'b1) begin
            bad++;
            $display("FAIL dbz_sticky got=%b want=1", dbz_v[0]);
        end
        issue(1, 1'b0, 32'd9, 32'd3, 32'd0, 32'd3, 1'b0, "after_dbz");
        total++;
        if (dbz_v[0] !== 1'b0) begin
            bad++;
            $display("FAIL dbz_clear got=%b want=0", dbz_v[0]);
        end
        drain("after_dbz");
    endtask

    task automatic test_busy_rules();
        mtlo  = 1'b1;
        wdata = 32'hAAAA_0000;
        @(negedge clk);
        mtlo = 1'b0;
        total++;
        if (lo_v[0] !== 32'hAAAA_0000) begin
            bad++;
            $display("FAIL mtlo_idle got=%h want=aaaa0000", lo_v[0]);
        end
        issue(1, 1'b0, 32'd1000, 32'd10, 32'd0, 32'd100, 1'b0, "busy_div");
        @(negedge clk);
        start_v[0] = 1'b1;
        op_a       = 32'd77;
        op_b       = 32'd5;
        mtlo       = 1'b1;
        wdata      = 32'h0000_1234;
        repeat (2) @(negedge clk);
        start_v[0] = 1'b0;
        mtlo       = 1'b0;
        total++;
        if (lo_v[0] !== 32'hAAAA_0000) begin
            bad++;
            $display("FAIL mtlo_busy got=%h want=aaaa0000", lo_v[0]);
        end
        drain("busy_div");

        mthi  = 1'b1;
        wdata = 32'hDEAD_0000;
        issue(1, 1'b0, 32'd50, 32'd8, 32'd2, 32'd6, 1'b0, "mthi_start");
        total++;
        if (hi_v[0] !== 32'hDEAD_0000) begin
            bad++;
            $display("FAIL mthi_start_hi got=%h want=dead0000", hi_v[0]);
        end
        drain("mthi_start");

        mthi  = 1'b1;
        mtlo  = 1'b1;
        wdata = 32'h5A5A_A5A5;
        @(negedge clk);
        mthi = 1'b0;
        mtlo = 1'b0;
        total++;
        if (hi_v[0] !== 32'h5A5A_A5A5 || lo_v[0] !== 32'h5A5A_A5A5) begin
            bad++;
            $display("FAIL mthi_mtlo_both got=%h/%h want=5a5aa5a5/5a5aa5a5", hi_v[0], lo_v[0]);
        end
    endtask

    task automatic test_reset_mid();
        issue(1, 1'b0, 32'd200, 32'd9, 32'd2, 32'd22, 1'b0, "pre_reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        total++;
        if (hi_v[0] !== 32'd0 || lo_v[0] !== 32'd0 || busy_v[0] !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid got hi=%h lo=%h busy=%b want=0/0/0", hi_v[0], lo_v[0], busy_v[0]);
        end
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            total++;
            if (done_v[0] !== 1'b0) begin
                bad++;
                $display("FAIL reset_mid_done cycle%0d got=%b want=0", c, done_v[0]);
            end
        end
        issue(1, 1'b0, 32'd200, 32'd9, 32'd2, 32'd22, 1'b0, "post_reset");
        drain("post_reset");
    endtask

    task automatic test_back_to_back_sweep();
        logic        s;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] r;
        for (int n = 0; n < 24; n++) begin
            s = 1'($urandom_range(0, 1));
            a = (n % 7 == 3) ? 32'h8000_0000 : $urandom;
            case ($urandom_range(0, 5))
                0:       b = 32'd0;
                1:       b = 32'($urandom_range(1, 15));
                2:       b = 32'd0 - 32'($urandom_range(1, 15));
                3:       b = 32'hFFFF_FFFF;
                default: b = $urandom;
            endcase
            r = ref_div(s, a, b);
            issue(7, s, a, b, r[63:32], r[31:0], (b == 32'd0), "sweep");
            drain("sweep");
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired want=test completion");
        $fatal(1, "watchdog");
    end

    initial begin
        total     = 0;
        bad       = 0;
        rst_n     = 1'b0;
        is_signed = 1'b0;
        mthi      = 1'b0;
        mtlo      = 1'b0;
        op_a      = '0;
        op_b      = '0;
        wdata     = '0;
        for (int i = 0; i < NDUT; i++) start_v[i] = 1'b0;
        fork
            monitor();
        join_none
        test_reset();
        test_unsigned();
        test_signed();
        test_ovf_zero();
        test_busy_rules();
        test_reset_mid();
        test_back_to_back_sweep();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
